// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared types and helpers for the FIFO write-port arbiter
package fifo_arb_pkg;

    typedef enum logic {IDLE, BURST} arb_state_t;

    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// rr_picker: combinational round-robin pick, search starts just after last
module rr_picker #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);

    logic [IW-1:0]  start;
    logic [IW-1:0]  k;
    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;
    logic [IW:0]    sum;

    // rotate so the first candidate sits at bit 0, pick lowest, rotate back
    assign start = (last == IW'(N - 1)) ? '0 : last + IW'(1);
    assign dbl   = {req, req} >> start;
    assign rot   = dbl[N-1:0];

    always_comb begin
        k = '0;
        for (int i = N - 1; i >= 0; i--)
            if (rot[i]) k = IW'(i);
    end

    assign sum = {1'b0, start} + {1'b0, k};
    assign idx = (sum >= (IW + 1)'(N)) ? IW'(sum - (IW + 1)'(N)) : sum[IW-1:0];
    assign any = |req;
    assign gnt = any ? (N'(1) << idx) : '0;

endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin burst arbiter sharing one FIFO write port
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int  NUM_REQ   = 4,
    parameter int  WIDTH     = 8,
    parameter int  MAX_BURST = 4,
    localparam int ID_W      = id_width(NUM_REQ),
    localparam int CW        = $clog2(MAX_BURST + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic                     fifo_full,
    output logic                     fifo_write,
    output logic [WIDTH-1:0]         fifo_data,
    output logic                     gnt_valid,
    output logic [ID_W-1:0]          gnt_id,
    output logic                     locked
);

    arb_state_t        state;
    logic [ID_W-1:0]   owner;
    logic [ID_W-1:0]   last_owner;
    logic [ID_W-1:0]   pick_id;
    logic [ID_W-1:0]   id;
    logic [CW-1:0]     burst_cnt;
    logic [NUM_REQ-1:0] pick_gnt;
    logic [NUM_REQ-1:0] gnt;
    logic [NUM_REQ-1:0] xfer;
    logic              pick_any;
    logic              lk;
    logic              gv;

    assign lk = (state == BURST) & req_valid[owner];

    // a released burst searches from owner+1 even before last_owner catches up
    rr_picker #(.N(NUM_REQ), .IW(ID_W)) u_pick (
        .req  (req_valid),
        .last (state == BURST ? owner : last_owner),
        .gnt  (pick_gnt),
        .idx  (pick_id),
        .any  (pick_any)
    );

    assign id         = lk ? owner : pick_id;
    assign gv         = ~rst & (lk | pick_any);
    assign gnt        = gv ? (lk ? (NUM_REQ'(1) << owner) : pick_gnt) : '0;
    assign req_ready  = gnt & {NUM_REQ{~fifo_full}};
    assign xfer       = req_valid & req_ready;
    assign fifo_write = |xfer;
    assign fifo_data  = gv ? req_data[id*WIDTH +: WIDTH] : '0;
    assign gnt_valid  = gv;
    assign gnt_id     = gv ? id : '0;
    assign locked     = ~rst & lk;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            owner      <= '0;
            last_owner <= ID_W'(NUM_REQ - 1);
            burst_cnt  <= '0;
        end else if (!fifo_full) begin
            if (lk) begin
                if (burst_cnt == CW'(MAX_BURST - 1)) begin
                    state      <= IDLE;
                    last_owner <= owner;
                    burst_cnt  <= '0;
                end else begin
                    burst_cnt <= burst_cnt + CW'(1);
                end
            end else if (fifo_write && MAX_BURST > 1) begin
                state     <= BURST;
                owner     <= id;
                burst_cnt <= CW'(1);
                if (state == BURST) last_owner <= owner;
            end else begin
                state     <= IDLE;
                burst_cnt <= '0;
                if (state == BURST) last_owner <= owner;
                else if (fifo_write) last_owner <= id;
            end
        end
    end

endmodule
